// File: rtl/div_pkg.sv
// Shared definitions for the sequential 16/8 divider.
// Build option: DIV16BY8_RADIX4_EN selects two restoring steps per cycle.
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;

  // Quotient/remainder reported for divide-by-zero and quotient overflow
  localparam logic [7:0] ERR_Q = 8'hFF;
  localparam logic [7:0] ERR_R = 8'hFF;

`ifdef DIV16BY8_RADIX4_EN
  // Two quotient bits per CALC cycle: counter runs 0..3
  localparam logic [2:0] LAST_CNT = 3'd3;
`else
  // One quotient bit per CALC cycle: counter runs 0..7
  localparam logic [2:0] LAST_CNT = 3'd7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [8:0]           rem,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [8:0]           rem_next,
  output logic                 qbit
);

  logic [9:0] t;
  logic [8:0] diff;

  // Trial subtraction; rem < divisor keeps the result within 9 bits
  always_comb begin
    t        = {rem, bit_in};
    diff     = t[8:0] - {1'b0, divisor};
    rem_next = t[8:0];
    qbit     = 1'b0;
    if (t >= {2'b00, divisor}) begin
      rem_next = diff;
      qbit     = 1'b1;
    end
  end

endmodule

// File: rtl/div16by8_seq.sv
// Sequential unsigned 16/8 restoring divider with valid/ready on both sides.
// Build option: DIV16BY8_RADIX4_EN chains two div_step instances per cycle.
module div16by8_seq
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] P,
  input  logic [DIVISOR_W-1:0]  B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            Q,
  output logic [7:0]            R,
  output logic                  div_zero,
  output logic                  ovf
);

  state_t      state_reg, state_next;
  logic [8:0]  rem_reg;
  logic [7:0]  sh_reg;      // remaining dividend bits on top, quotient bits fill from LSB
  logic [7:0]  b_reg;
  logic [2:0]  cnt_reg;
  logic [7:0]  q_reg, r_reg;
  logic        dz_reg, ovf_reg;

  logic        bad_div_zero, bad_ovf;
  logic [8:0]  rem_a;
  logic        qbit_a;
  logic [8:0]  rem_step;
  logic [7:0]  sh_step;

  assign bad_div_zero = (B == 8'd0);
  assign bad_ovf      = (P[15:8] >= B);

  div_step u_step_a (
    .rem      (rem_reg),
    .bit_in   (sh_reg[7]),
    .divisor  (b_reg),
    .rem_next (rem_a),
    .qbit     (qbit_a)
  );

`ifdef DIV16BY8_RADIX4_EN
  logic [8:0] rem_b;
  logic       qbit_b;

  div_step u_step_b (
    .rem      (rem_a),
    .bit_in   (sh_reg[6]),
    .divisor  (b_reg),
    .rem_next (rem_b),
    .qbit     (qbit_b)
  );

  assign rem_step = rem_b;
  assign sh_step  = {sh_reg[5:0], qbit_a, qbit_b};
`else
  assign rem_step = rem_a;
  assign sh_step  = {sh_reg[6:0], qbit_a};
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and handshake outputs; DONE never accepts new operands
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (bad_div_zero || bad_ovf) state_next = ST_DONE;
          else                         state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_reg == LAST_CNT) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers held through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg <= 9'd0;
      sh_reg  <= 8'd0;
      b_reg   <= 8'd0;
      cnt_reg <= 3'd0;
      q_reg   <= 8'd0;
      r_reg   <= 8'd0;
      dz_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            b_reg <= B;
            if (bad_div_zero) begin
              q_reg   <= ERR_Q;
              r_reg   <= ERR_R;
              dz_reg  <= 1'b1;
              ovf_reg <= 1'b0;
            end else if (bad_ovf) begin
              q_reg   <= ERR_Q;
              r_reg   <= ERR_R;
              dz_reg  <= 1'b0;
              ovf_reg <= 1'b1;
            end else begin
              rem_reg <= {1'b0, P[15:8]};
              sh_reg  <= P[7:0];
              cnt_reg <= 3'd0;
              dz_reg  <= 1'b0;
              ovf_reg <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          rem_reg <= rem_step;
          sh_reg  <= sh_step;
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == LAST_CNT) begin
            q_reg <= sh_step;
            r_reg <= rem_step[7:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Q        = q_reg;
  assign R        = r_reg;
  assign div_zero = dz_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_div16by8_seq.sv
// Scoreboard bench for div16by8_seq: stimulus pushes expected results computed
// with plain integer division; a negedge monitor pops and compares.
module tb_div16by8_seq;

`ifdef DIV16BY8_RADIX4_EN
  localparam int CALC_LAT = 4;
`else
  localparam int CALC_LAT = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] P = 16'd0;
  logic [7:0]  B = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  Q, R;
  logic        div_zero, ovf;

  div16by8_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Inputs are changed just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: plain integer division with the two error cases
  function automatic exp_t model(input logic [15:0] p, input logic [7:0] b);
    exp_t e;
    int pi, bi;
    pi = p;
    bi = b;
    e.p = p; e.b = b; e.dz = 0; e.ov = 0;
    e.q = 8'hFF; e.r = 8'hFF; e.lat = 0; e.acc = 0;
    if (bi == 0) e.dz = 1;
    else if (pi / bi > 255) e.ov = 1;
    else begin
      e.q   = 8'(pi / bi);
      e.r   = 8'(pi % bi);
      e.lat = CALC_LAT;
    end
    return e;
  endfunction

  task automatic issue(input logic [15:0] p, input logic [7:0] b);
    exp_t e;
    int g = 0;
    while (!in_ready && g < 200) begin tick(); g++; end
    if (!in_ready) fail_now("in_ready_wait");
    else begin
      P = p; B = b; in_valid = 1'b1;
      e = model(p, b);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      $display("issue P=%0d B=%0d -> Q=%0d R=%0d dz=%0d ovf=%0d", p, b, e.q, e.r, e.dz, e.ov);
      tick();
      in_valid = 1'b0;
      P = 16'($urandom);
      B = 8'($urandom);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 400) begin tick(); g++; end
    if (exp_q.size() != 0) fail_now("drain");
  endtask

  // Monitor: latency is counted in rising edges from the accept edge to the
  // edge after which out_valid is seen (error results appear right after accept)
  bit          presenting = 0;
  logic [17:0] cap;
  always @(negedge clk) begin
    if (rst) presenting = 0;
    else if (out_valid) begin
      if (!presenting) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_valid");
        else begin
          presenting = 1;
          cap = {Q, R, div_zero, ovf};
          check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
        end
      end else begin
        check("hold_stable", {Q, R, div_zero, ovf}, cap);
      end
      if (presenting && out_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        presenting = 0;
        $display("result P=%0d B=%0d Q=%0d R=%0d dz=%0d ovf=%0d", e.p, e.b, Q, R, div_zero, ovf);
        check("Q", Q, e.q);
        check("R", R, e.r);
        check("div_zero", div_zero, e.dz);
        check("ovf", ovf, e.ov);
        if (!e.dz && !e.ov) begin
          check("identity", Q * e.b + R, e.p);
          check("r_lt_b", (R < e.b) ? 1 : 0, 1);
        end
      end
    end
  end

  initial begin
    int g;
    logic [15:0] rp;
    logic [7:0]  rb;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_Q", Q, 0);
    check("rst_R", R, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_ovf", ovf, 0);

    // Directed cases, consumer always ready
    issue(16'd1000, 8'd7);     drain();
    issue(16'hFEFF, 8'hFF);    drain();
    issue(16'h1234, 8'h00);    drain();
    issue(16'h0800, 8'h08);    drain();

    // Backpressure: result held for 5 stalled cycles
    out_ready = 1'b0;
    issue(16'd100, 8'd9);
    g = 0;
    while (!out_valid && g < 40) begin tick(); g++; end
    if (!out_valid) fail_now("bp_out_valid_wait");
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid_held", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    check("bp_in_ready_before_hs", in_ready, 0);
    tick();
    check("bp_in_ready_after_hs", in_ready, 1);
    check("bp_out_valid_after_hs", out_valid, 0);
    drain();

    // Reset during the third CALC cycle aborts the operation
    issue(16'd500, 8'd3);
    tick();
    tick();
    rst = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_Q", Q, 0);
    check("abort_R", R, 0);
    check("abort_flags", {div_zero, ovf}, 0);
    for (int i = 0; i < CALC_LAT + 3; i++) begin
      tick();
      check("abort_no_result", out_valid, 0);
    end
    issue(16'd500, 8'd3);      drain();

    // Random sweep with input gaps and random consumer stalls
    rand_rdy = 1;
    for (int n = 0; n < 3000; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int k = 0; k < gap; k++) tick();
      rb = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 8'd0;
      if (rb != 0 && $urandom_range(0, 1) == 1)
        rp = 16'($urandom_range(0, int'(rb) * 256 - 1));
      else
        rp = 16'($urandom);
      issue(rp, rb);
    end
    drain();
    rand_rdy = 0;
    out_ready = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
